// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, x/y scan counters, hsync/vsync/active decodes.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             run;
    logic             div_last;
    logic             x_wrap;
    logic             y_wrap;

    // Half-open window test shared by the sync decodes.
    function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    assign div_last = (div_cnt == DIV_LAST);
    assign x_wrap   = (x == X_LAST);
    assign y_wrap   = (y == Y_LAST);

    // Divider and scan counters; div_cnt only runs once run is set so the
    // first pixel after reset release is a full CLK_DIV clocks long.
    always_ff @(posedge clk) begin
        if (rst) begin
            run     <= 1'b0;
            div_cnt <= '0;
            x       <= '0;
            y       <= '0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt <= '0;
`endif
        end else begin
            run <= 1'b1;
            if (run) begin
                if (div_last) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
            end
            if (pix_en) begin
                if (x_wrap) begin
                    x <= '0;
                    if (y_wrap) begin
                        y <= '0;
`ifdef VGA_FRAME_CNT_EN
                        frame_cnt <= frame_cnt + 16'd1;
`endif
                    end else begin
                        y <= y + 10'd1;
                    end
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

    // Zero-latency decodes of the registered counters, forced idle while run=0.
    assign pix_en      = run & div_last;
    assign active      = run & (x < X_ACT) & (y < Y_ACT);
    assign hsync       = (run && in_window(x, HS_BEG, HS_END)) ? H_POL : ~H_POL;
    assign vsync       = (run && in_window(y, VS_BEG, VS_END)) ? V_POL : ~V_POL;
    assign line_start  = pix_en & (x == 10'd0);
    assign frame_start = line_start & (y == 10'd0);

endmodule
